mips_fetch_unit: RTL

//  Instruction-fetch stage of the MIPS core. Drives the instruction address,

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mips_pc_reg.sv | 36 +++
 rtl/mips_fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// Holds the IF/ID bundle, fetch FSM states and SYSCALL decode.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic is_syscall(input logic [31:0] w);
        return (w[31:26] == OP_SPECIAL) && (w[5:0] == FN_SYSCALL);
    endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register: async reset, load, hold or +4 increment.
// A load takes priority over an increment; neither means hold.
module mips_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] target_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {target_i[31:2], 2'b00};
        end else if (inc_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC, IF/ID register and SYSCALL drain FSM.
// Once a SYSCALL leaves ID the unit freezes until reset.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        halted
);

    fetch_state_t state_q;
    if_id_t       if_id_q;
    logic         halted_q;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         sys_hit;
    logic         pc_load;
    logic         pc_inc;

    assign pc_plus4 = pc + 32'd4;
    assign sys_hit  = HALT_ON_SYSCALL && is_syscall(inst);

    // A captured SYSCALL parks the PC; only a redirect moves it again.
    assign pc_load = (state_q != HALTED) && redirect_valid;
    assign pc_inc  = (state_q == RUN) && !redirect_valid
                     && !stall && !sys_hit;

    mips_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst_b),
        .load_i   (pc_load),
        .target_i (redirect_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= RUN;
            if_id_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        if_id_q.valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_q.valid    <= 1'b1;
                        if_id_q.inst     <= inst;
                        if_id_q.pc       <= pc;
                        if_id_q.pc_plus4 <= pc_plus4;
                        if (sys_hit) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        if_id_q.valid <= 1'b0;
                        state_q       <= RUN;
                    end else if (!stall) begin
                        if_id_q.valid <= 1'b0;
                        halted_q      <= 1'b1;
                        state_q       <= HALTED;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign inst_addr   = pc;
    assign id_valid    = if_id_q.valid;
    assign id_inst     = if_id_q.inst;
    assign id_pc       = if_id_q.pc;
    assign id_pc_plus4 = if_id_q.pc_plus4;
    assign halted      = halted_q;

endmodule
